gpio_mmio_port: RTL and testbench

GPIO_MMIO_PORT -- requirements
Module: gpio_mmio_port

---
 rtl/gpio_mmio_port_pkg.sv | 17 +
 rtl/gpio_mmio_port_sync_fifo.sv | 60 ++++++
 rtl/gpio_mmio_port.sv | 134 +++++++++++++
 tb/tb_gpio_mmio_port.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gpio_mmio_port_pkg.sv
// Shared definitions for the GPIO MMIO port: run FSM encoding and default map.
package gpio_mmio_port_pkg;

    // Run-control states; encoding is fixed so software/debug views stay stable.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } run_state_e;

    // Default address of channel 0.
    localparam logic [31:0] DEFAULT_BASE = 32'hABCD;

    // Width of the channel index carried in the write log (up to 16 channels).
    localparam int unsigned CH_IDX_W = 4;

endpackage

// File: rtl/gpio_mmio_port_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Ports: clk, rst_n (sync, active-low), push/wdata, pop, rdata (head),
//        count (0..DEPTH), full.
module sync_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // Pointer and count state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty so it has no reset.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/gpio_mmio_port.sv
// Memory-mapped GPIO output port with run control and a write-log FIFO.
// Ports: clk, rst_n (sync, active-low); addr/st_data/st_en store bus;
//        pc/end_pc/start run control; gpio/gpio_upd channel outputs;
//        run_en/done FSM status; log_* FIFO read side; overflow sticky flag.
module gpio_mmio_port
    import gpio_mmio_port_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       N_CH      = 4,
    parameter logic [ADDR_W-1:0] BASE      = ADDR_W'(DEFAULT_BASE),
    parameter int unsigned       LOG_DEPTH = 8,
    parameter int unsigned       WR_QUAL   = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]           st_data,
    input  logic                        st_en,
    input  logic [ADDR_W-1:0]           pc,
    input  logic [ADDR_W-1:0]           end_pc,
    input  logic                        start,
    output logic [N_CH*DATA_W-1:0]      gpio,
    output logic [N_CH-1:0]             gpio_upd,
    output logic                        run_en,
    output logic                        done,
    output logic                        log_valid,
    input  logic                        log_ready,
    output logic [DATA_W-1:0]           log_data,
    output logic [CH_IDX_W-1:0]         log_ch,
    output logic [$clog2(LOG_DEPTH):0]  log_count,
    output logic                        overflow
);

    localparam int unsigned LOG_W = CH_IDX_W + DATA_W;

    run_state_e              state_q, state_d;
    logic                    run_en_q, run_en_d;
    logic                    done_q, done_d;
    logic [N_CH*DATA_W-1:0]  gpio_q, gpio_d;
    logic [N_CH-1:0]         gpio_upd_q, gpio_upd_d;
    logic                    overflow_q, overflow_d;

    logic [ADDR_W-1:0]       offset_c;
    logic                    hit_c;
    logic                    pop_c;
    logic                    fifo_full;
    logic [LOG_W-1:0]        fifo_rdata;

    // Offset from BASE in ADDR_W bits, so a map that wraps past 2^ADDR_W still decodes.
    assign offset_c = addr - BASE;
    assign hit_c    = run_en_q && (st_en || (WR_QUAL == 0)) && (offset_c < ADDR_W'(N_CH));
    assign pop_c    = log_valid && log_ready;

    // Run FSM: state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Run FSM: next state; start is ignored while running.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_RUN;
            ST_RUN:    if (pc == end_pc) state_d = ST_HALTED;
            ST_HALTED: if (start) state_d = ST_RUN;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Run FSM outputs, decoded from the next state so they register alongside it.
    always_comb begin
        run_en_d = (state_d == ST_RUN);
        done_d   = (state_d == ST_HALTED);
    end

    // Channel update and sticky overflow.
    always_comb begin
        gpio_d     = gpio_q;
        gpio_upd_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (hit_c && (offset_c == ADDR_W'(i))) begin
                gpio_d[i*DATA_W +: DATA_W] = st_data;
                gpio_upd_d[i]              = 1'b1;
            end
        end
        overflow_d = overflow_q || (hit_c && fifo_full && !pop_c);
    end

    // Output and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_en_q   <= 1'b0;
            done_q     <= 1'b0;
            gpio_q     <= '0;
            gpio_upd_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            run_en_q   <= run_en_d;
            done_q     <= done_d;
            gpio_q     <= gpio_d;
            gpio_upd_q <= gpio_upd_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (LOG_W),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (hit_c),
        .wdata ({CH_IDX_W'(offset_c), st_data}),
        .pop   (pop_c),
        .rdata (fifo_rdata),
        .count (log_count),
        .full  (fifo_full)
    );

    assign log_valid = (log_count != '0);
    assign log_data  = fifo_rdata[DATA_W-1:0];
    assign log_ch    = fifo_rdata[LOG_W-1:DATA_W];
    assign gpio      = gpio_q;
    assign gpio_upd  = gpio_upd_q;
    assign run_en    = run_en_q;
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_gpio_mmio_port.sv
// Self-checking bench for gpio_mmio_port: directed scenarios then random
// traffic, all compared every cycle against a behavioural model.
module tb_gpio_mmio_port;

    localparam logic [31:0] BASE = 32'hABCD;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n, st_en, start, log_ready;
    logic [31:0] addr, st_data, pc, end_pc;

    logic [127:0] gpio;
    logic [3:0]   gpio_upd, log_ch, log_count;
    logic         run_en, done, log_valid, overflow;
    logic [31:0]  log_data;

    // Legacy-mode instance whose map wraps past 2^32: channels at FFFFFFFE, FFFFFFFF, 0, 1.
    logic [127:0] l_gpio;
    logic [3:0]   l_gpio_upd, l_log_ch, l_log_count;
    logic         l_run_en, l_done, l_log_valid, l_overflow;
    logic [31:0]  l_log_data;

    always #5 clk = ~clk;

    gpio_mmio_port dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .st_data(st_data), .st_en(st_en),
        .pc(pc), .end_pc(end_pc), .start(start), .gpio(gpio), .gpio_upd(gpio_upd),
        .run_en(run_en), .done(done), .log_valid(log_valid), .log_ready(log_ready),
        .log_data(log_data), .log_ch(log_ch), .log_count(log_count), .overflow(overflow)
    );

    gpio_mmio_port #(.BASE(32'hFFFF_FFFE), .WR_QUAL(0)) dut_legacy (
        .clk(clk), .rst_n(rst_n), .addr(addr), .st_data(st_data), .st_en(st_en),
        .pc(pc), .end_pc(end_pc), .start(start), .gpio(l_gpio), .gpio_upd(l_gpio_upd),
        .run_en(l_run_en), .done(l_done), .log_valid(l_log_valid), .log_ready(1'b1),
        .log_data(l_log_data), .log_ch(l_log_ch), .log_count(l_log_count), .overflow(l_overflow)
    );

    // Behavioural model of the main instance.
    typedef struct { logic [3:0] ch; logic [31:0] d; } ent_t;
    logic [31:0] m_gpio [4];
    logic [3:0]  m_upd;
    bit          m_running, m_halted, m_ovf;
    ent_t        m_q [$];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_tick();
        logic [31:0] off;
        bit hit, pop;
        off = addr - BASE;
        hit = m_running && st_en && (off < 32'd4);
        pop = (m_q.size() != 0) && log_ready;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_gpio[i] = '0;
            m_upd = '0; m_running = 0; m_halted = 0; m_ovf = 0;
            m_q.delete();
        end else begin
            m_upd = '0;
            if (hit) begin
                m_gpio[off[1:0]] = st_data;
                m_upd[off[1:0]]  = 1'b1;
            end
            if (pop) void'(m_q.pop_front());
            if (hit) begin
                if (m_q.size() < DEPTH) m_q.push_back('{ch: off[3:0], d: st_data});
                else m_ovf = 1;
            end
            if (m_running) begin
                if (pc == end_pc) begin m_running = 0; m_halted = 1; end
            end else if (start) begin
                m_running = 1; m_halted = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("gpio", gpio, {m_gpio[3], m_gpio[2], m_gpio[1], m_gpio[0]});
        chk("gpio_upd", gpio_upd, m_upd);
        chk("run_en", run_en, m_running);
        chk("done", done, m_halted);
        chk("log_count", log_count, m_q.size());
        chk("log_valid", log_valid, m_q.size() != 0);
        chk("overflow", overflow, m_ovf);
        if (m_q.size() != 0) begin
            chk("log_data", log_data, m_q[0].d);
            chk("log_ch", log_ch, m_q[0].ch);
        end
    endtask

    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_gpio[i] = '0;
        m_upd = '0;
        rst_n = 0; st_en = 0; start = 0; log_ready = 0;
        addr = '0; st_data = '0; pc = '0; end_pc = 32'hFFFF_FFF0;

        // Reset for two cycles, then start and write channel 0.
        step(); step();
        chk("rst_gpio", gpio, '0);
        chk("rst_run_en", run_en, 1'b0);
        rst_n = 1; start = 1;
        step();
        start = 0; addr = BASE; st_en = 1; st_data = 32'h1234;
        step();
        chk("wr0_gpio", gpio[31:0], 32'h1234);
        chk("wr0_upd", gpio_upd, 4'b0001);
        chk("wr0_count", log_count, 4'd1);
        chk("wr0_ch", log_ch, 4'd0);

        // Qualified write without st_en is ignored; legacy instance writes on address alone.
        addr = 32'hABCF; st_en = 0; st_data = 32'd5;
        step();
        chk("qual_noupd", gpio[95:64], 32'd0);
        addr = 32'h0;
        step();
        chk("legacy_wrap_gpio", l_gpio[95:64], 32'd5);
        chk("legacy_wrap_upd", l_gpio_upd, 4'b0100);
        addr = 32'h2;
        step();
        chk("legacy_past_end", l_gpio_upd, 4'b0000);

        // Drain the log, then run to end_pc.
        log_ready = 1;
        step(); step();
        end_pc = 32'd92;
        for (int p = 0; p < 92; p += 4) begin pc = p; step(); end
        pc = 32'd92; addr = BASE + 1; st_en = 1; st_data = 32'hAA;
        step();
        chk("halt_last_hit", gpio[63:32], 32'hAA);
        chk("halt_run_en", run_en, 1'b0);
        chk("halt_done", done, 1'b1);
        pc = 32'd96; st_data = 32'hBB;
        step();
        chk("halt_ignored", gpio[63:32], 32'hAA);
        st_en = 0; start = 1; pc = 32'd0;
        step();
        chk("restart_run_en", run_en, 1'b1);
        start = 0;

        // Overflow: nine hits with the log stalled, then drain in order.
        step();
        log_ready = 0; addr = BASE + 3; st_en = 1;
        for (int i = 0; i < 9; i++) begin st_data = 100 + i; step(); end
        chk("ovf_count", log_count, 4'd8);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_gpio", gpio[127:96], 32'd108);
        st_en = 0; log_ready = 1;
        for (int i = 0; i < 9; i++) step();
        chk("ovf_drained", log_valid, 1'b0);

        // Push and pop together while full.
        rst_n = 0; step();
        rst_n = 1; start = 1; step();
        start = 0; log_ready = 0; addr = BASE; st_en = 1;
        for (int i = 0; i < 8; i++) begin st_data = 200 + i; step(); end
        st_data = 32'd300; log_ready = 1;
        step();
        chk("full_pp_count", log_count, 4'd8);
        chk("full_pp_ovf", overflow, 1'b0);
        st_en = 0;
        for (int i = 0; i < 7; i++) step();
        chk("full_pp_tail", log_data, 32'd300);
        step();

        // Reset during a run with a hit pending.
        log_ready = 0; addr = BASE + 2; st_en = 1; st_data = 32'h77;
        step();
        rst_n = 0; start = 1; st_data = 32'h88;
        step();
        chk("midrst_gpio", gpio, '0);
        chk("midrst_run_en", run_en, 1'b0);
        chk("midrst_count", log_count, 4'd0);

        // Random traffic around the map.
        rst_n = 1; start = 1; step();
        for (int n = 0; n < 400; n++) begin
            rst_n     = ($urandom_range(0, 63) != 0);
            start     = ($urandom_range(0, 7) == 0);
            addr      = BASE - 2 + $urandom_range(0, 7);
            st_en     = $urandom_range(0, 1) == 1;
            st_data   = $urandom;
            log_ready = $urandom_range(0, 2) == 0;
            pc        = $urandom_range(0, 31) * 4;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
